// File: rtl/csa_seq_ctrl.sv
// csa_seq_ctrl: WIDTH-bit add/subtract sequencer that reuses one 8-bit
// carry-skip slice adder, one slice per clock, LSB slice first.
module csa_seq_ctrl #(
    parameter int WIDTH = 32,
    localparam int NSLICE = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;
    logic             cout_q;
    logic             ovf_q;

    logic [7:0]       sl_a;
    logic [7:0]       sl_b;
    logic [7:0]       sl_s_d;
    logic             sl_c_d;
    logic             ci;
    logic             c_mid;
    logic             p_lo;
    logic             p_hi;
    logic [1:0]       fa;
    logic             last;
    logic             ovf_d;

    // NAND-only full adder; returns {carry, sum}
    function automatic logic [1:0] nand_fa(input logic a, input logic b,
                                           input logic c);
        logic n1, n2, n3, x, n4, n5, n6;
        n1 = ~(a & b);
        n2 = ~(a & n1);
        n3 = ~(b & n1);
        x  = ~(n2 & n3);
        n4 = ~(x & c);
        n5 = ~(x & n4);
        n6 = ~(c & n4);
        return {~(n1 & n4), ~(n5 & n6)};
    endfunction

    assign sl_a = opa_q[{idx_q, 3'b000} +: 8];
    assign sl_b = opb_q[{idx_q, 3'b000} +: 8];
    assign last = (idx_q == IDXW'(NSLICE - 1));

    // Slice adder: two 4-bit ripple groups, each bypassed when fully propagating
    always_comb begin
        sl_s_d = '0;
        fa     = '0;
        p_lo   = &(sl_a[3:0] ^ sl_b[3:0]);
        p_hi   = &(sl_a[7:4] ^ sl_b[7:4]);
        ci     = carry_q;
        for (int i = 0; i < 4; i++) begin
            fa        = nand_fa(sl_a[i], sl_b[i], ci);
            sl_s_d[i] = fa[0];
            ci        = fa[1];
        end
        c_mid = p_lo ? carry_q : ci;
        ci    = c_mid;
        for (int i = 4; i < 8; i++) begin
            fa        = nand_fa(sl_a[i], sl_b[i], ci);
            sl_s_d[i] = fa[0];
            ci        = fa[1];
        end
        sl_c_d = p_hi ? c_mid : ci;
    end

    // Overflow judged on the stored (possibly inverted) B and the new MSB
    assign ovf_d = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                   (sl_s_d[7] != opa_q[WIDTH-1]);

    // Sequencer FSM: capture, per-slice accumulate, hold result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        opa_q   <= in_a;
                        opb_q   <= in_sub ? ~in_b : in_b;
                        carry_q <= in_sub | in_cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[{idx_q, 3'b000} +: 8] <= sl_s_d;
                    carry_q <= sl_c_d;
                    if (last) begin
                        cout_q  <= sl_c_d;
                        ovf_q   <= ovf_d;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule
